// File: rtl/uart_rx_fifo.sv
// 8N1 UART receiver feeding a show-ahead byte FIFO with a valid/ready pop interface.
// Define UART_RX_PARITY_EN to add an even-parity bit between the data and stop bits.
module uart_rx_fifo #(
    parameter int CLK_MHZ    = 27,
    parameter int BAUD       = 115200,
    parameter int FIFO_DEPTH = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       i_rx,
    output logic [7:0] o_data,
    output logic       o_valid,
    input  logic       i_ready,
    output logic       o_frame_err,
    output logic       o_overrun,
    output logic       o_busy
);

    localparam int CLKS_PER_BIT = CLK_MHZ * 1000000 / BAUD;
    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam logic [CW-1:0] HALF = CW'(CLKS_PER_BIT / 2);
    localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);
    localparam logic [AW:0]   FULL_COUNT = (AW + 1)'(FIFO_DEPTH);

`ifdef UART_RX_PARITY_EN
    typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP, S_WAIT_IDLE} state_t;
`else
    typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_STOP, S_WAIT_IDLE} state_t;
`endif

    state_t        state_reg, state_next;
    logic [CW-1:0] cnt_reg, cnt_next;
    logic [2:0]    bit_reg, bit_next;
    logic [7:0]    shift_reg, shift_next;
    logic          rx_meta, rx_sync, rx_prev;
    logic          push, frame_bad;
`ifdef UART_RX_PARITY_EN
    logic          par_reg, par_next;
    logic          parity_ok;
    assign parity_ok = (par_reg == ^shift_reg);
`endif

    // Synchronizer and edge history idle high so reset never looks like a start bit
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rx_meta <= 1'b1;
            rx_sync <= 1'b1;
            rx_prev <= 1'b1;
        end else begin
            rx_meta <= i_rx;
            rx_sync <= rx_meta;
            rx_prev <= rx_sync;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg <= S_IDLE;
            cnt_reg   <= '0;
            bit_reg   <= '0;
            shift_reg <= '0;
`ifdef UART_RX_PARITY_EN
            par_reg   <= 1'b0;
`endif
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
            bit_reg   <= bit_next;
            shift_reg <= shift_next;
`ifdef UART_RX_PARITY_EN
            par_reg   <= par_next;
`endif
        end
    end

    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg + 1'b1;
        bit_next   = bit_reg;
        shift_next = shift_reg;
`ifdef UART_RX_PARITY_EN
        par_next   = par_reg;
`endif
        push       = 1'b0;
        frame_bad  = 1'b0;
        case (state_reg)
            S_IDLE: begin
                cnt_next = '0;
                if (rx_prev && !rx_sync) state_next = S_START;
            end
            S_START: begin
                if (cnt_reg == HALF) begin
                    cnt_next   = '0;
                    bit_next   = '0;
                    state_next = rx_sync ? S_IDLE : S_DATA;
                end
            end
            S_DATA: begin
                if (cnt_reg == LAST) begin
                    cnt_next   = '0;
                    shift_next = {rx_sync, shift_reg[7:1]};
                    bit_next   = bit_reg + 1'b1;
`ifdef UART_RX_PARITY_EN
                    if (bit_reg == 3'd7) state_next = S_PARITY;
`else
                    if (bit_reg == 3'd7) state_next = S_STOP;
`endif
                end
            end
`ifdef UART_RX_PARITY_EN
            S_PARITY: begin
                if (cnt_reg == LAST) begin
                    cnt_next   = '0;
                    par_next   = rx_sync;
                    state_next = S_STOP;
                end
            end
`endif
            S_STOP: begin
                // Leave on the mid-stop sample so a back-to-back start edge is caught
                if (cnt_reg == LAST) begin
                    cnt_next = '0;
`ifdef UART_RX_PARITY_EN
                    if (rx_sync && parity_ok) begin
                        push       = 1'b1;
                        state_next = S_IDLE;
                    end else begin
                        frame_bad  = 1'b1;
                        state_next = rx_sync ? S_IDLE : S_WAIT_IDLE;
                    end
`else
                    if (rx_sync) begin
                        push       = 1'b1;
                        state_next = S_IDLE;
                    end else begin
                        frame_bad  = 1'b1;
                        state_next = S_WAIT_IDLE;
                    end
`endif
                end
            end
            S_WAIT_IDLE: begin
                cnt_next = '0;
                if (rx_sync) state_next = S_IDLE;
            end
            default: state_next = S_IDLE;
        endcase
    end

    // Show-ahead FIFO
    logic [7:0]    mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr_reg, rd_ptr_reg;
    logic [AW:0]   count_reg;
    logic          frame_err_reg, overrun_reg;
    logic          full, pop, do_push;

    assign full    = (count_reg == FULL_COUNT);
    assign pop     = i_ready && (count_reg != '0);
    assign do_push = push && (!full || pop);

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr_reg] <= shift_reg;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_reg    <= '0;
            rd_ptr_reg    <= '0;
            count_reg     <= '0;
            frame_err_reg <= 1'b0;
            overrun_reg   <= 1'b0;
        end else begin
            if (do_push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
            if (pop)     rd_ptr_reg <= rd_ptr_reg + 1'b1;
            case ({do_push, pop})
                2'b10:   count_reg <= count_reg + 1'b1;
                2'b01:   count_reg <= count_reg - 1'b1;
                default: count_reg <= count_reg;
            endcase
            frame_err_reg <= frame_bad;
            overrun_reg   <= push && full && !pop;
        end
    end

    assign o_valid     = (count_reg != '0);
    assign o_data      = o_valid ? mem[rd_ptr_reg] : 8'h00;
    assign o_frame_err = frame_err_reg;
    assign o_overrun   = overrun_reg;
    assign o_busy      = (state_reg != S_IDLE);

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Self-checking bench for uart_rx_fifo: table-driven frames, hand-written corner cases,
// and random frames checked against a queue-based model of the receive path.
`timescale 1ns/1ps
module tb_uart_rx_fifo;

    localparam int CPB   = 27 * 1000000 / 115200;
    localparam int DEPTH = 8;
`ifdef UART_RX_PARITY_EN
    localparam int NB = 11;
`else
    localparam int NB = 10;
`endif

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       rx  = 1'b1;
    logic       ready = 1'b0;
    logic [7:0] o_data;
    logic       o_valid, o_frame_err, o_overrun, o_busy;

    uart_rx_fifo #(.CLK_MHZ(27), .BAUD(115200), .FIFO_DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst), .i_rx(rx), .o_data(o_data), .o_valid(o_valid),
        .i_ready(ready), .o_frame_err(o_frame_err), .o_overrun(o_overrun), .o_busy(o_busy)
    );

    always #5 clk = ~clk;

    int   n_vec = 0, n_bad = 0;
    int   cyc = 0, ferr_cnt = 0, ovr_cnt = 0, both_cnt = 0, rise_cyc = 0;
    int   start_cyc = 0;
    logic valid_q = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (o_frame_err) ferr_cnt <= ferr_cnt + 1;
        if (o_overrun) ovr_cnt <= ovr_cnt + 1;
        if (o_frame_err && o_overrun) both_cnt <= both_cnt + 1;
        if (o_valid && !valid_q) rise_cyc <= cyc;
        valid_q <= o_valid;
    end

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic wait_cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Drives start, 8 data bits LSB first, optional parity, and the stop bit; line left at stop level
    task automatic send_frame(input logic [7:0] d, input logic stop_bit, input logic par_flip);
        $display("frame %02h stop=%0b par_flip=%0b", d, stop_bit, par_flip);
        start_cyc = cyc;
        rx = 1'b0;
        wait_cycles(CPB);
        for (int i = 0; i < 8; i++) begin
            rx = d[i];
            wait_cycles(CPB);
        end
`ifdef UART_RX_PARITY_EN
        rx = (^d) ^ par_flip;
        wait_cycles(CPB);
`endif
        rx = stop_bit;
        wait_cycles(CPB);
    endtask

    task automatic pop_expect(input string nm, input logic [7:0] exp);
        int t = 0;
        @(negedge clk);
        while (!o_valid && t < 2 * CPB * NB) begin
            @(negedge clk);
            t++;
        end
        check({nm, "_valid"}, {31'd0, o_valid}, 32'd1);
        check({nm, "_data"}, {24'd0, o_data}, {24'd0, exp});
        $display("pop %02h (expected %02h)", o_data, exp);
        ready = 1'b1;
        @(posedge clk);
        #1;
        ready = 1'b0;
    endtask

    typedef struct {
        logic [7:0] data;
        logic       stop;
        int         low_bits;
        logic       exp_push;
        int         exp_ferr;
    } vec_t;

    vec_t vecs[7];
    logic [7:0] q[$];

    initial begin
        int base_f, base_o, lat, lo, exp_f, exp_o;
        logic [7:0] d;
        logic stop, flip;

        vecs[0] = '{8'hA5, 1'b1, 0, 1'b1, 0};
        vecs[1] = '{8'h3C, 1'b0, 3, 1'b0, 1};
        vecs[2] = '{8'h11, 1'b1, 0, 1'b1, 0};
        vecs[3] = '{8'h00, 1'b1, 0, 1'b1, 0};
        vecs[4] = '{8'hFF, 1'b1, 0, 1'b1, 0};
        vecs[5] = '{8'h80, 1'b0, 0, 1'b0, 1};
        vecs[6] = '{8'h5B, 1'b1, 0, 1'b1, 0};
        lo = (2 * NB - 1) * CPB / 2;

        // Reset state
        #2 rst = 1'b1;
        wait_cycles(4);
        @(negedge clk);
        check("rst_valid", {31'd0, o_valid}, 32'd0);
        check("rst_data", {24'd0, o_data}, 32'd0);
        check("rst_busy", {31'd0, o_busy}, 32'd0);
        check("rst_ferr", {31'd0, o_frame_err}, 32'd0);
        check("rst_ovr", {31'd0, o_overrun}, 32'd0);
        @(posedge clk);
        #1 rst = 1'b0;
        wait_cycles(CPB);

        // Table of single frames, including a bad stop with the line held low
        for (int v = 0; v < 7; v++) begin
            base_f = ferr_cnt;
            send_frame(vecs[v].data, vecs[v].stop, 1'b0);
            if (vecs[v].low_bits > 0) begin
                wait_cycles(vecs[v].low_bits * CPB / 2);
                @(negedge clk);
                check("busy_while_low", {31'd0, o_busy}, 32'd1);
                wait_cycles(vecs[v].low_bits * CPB / 2);
            end
            rx = 1'b1;
            wait_cycles(2 * CPB);
            @(negedge clk);
            check("tbl_ferr_count", ferr_cnt - base_f, vecs[v].exp_ferr);
            check("tbl_busy_idle", {31'd0, o_busy}, 32'd0);
            check("tbl_valid", {31'd0, o_valid}, {31'd0, vecs[v].exp_push});
            if (vecs[v].exp_push) begin
                lat = rise_cyc - start_cyc;
                check("push_latency_window", (lat >= lo && lat <= lo + 12) ? 32'd1 : 32'd0, 32'd1);
                pop_expect("tbl_pop", vecs[v].data);
                @(negedge clk);
                check("tbl_empty_after_pop", {31'd0, o_valid}, 32'd0);
            end
        end

        // Nine back-to-back frames into a full FIFO with no consumer
        base_o = ovr_cnt;
        base_f = ferr_cnt;
        for (int i = 0; i < 9; i++) send_frame(8'(i), 1'b1, 1'b0);
        rx = 1'b1;
        wait_cycles(2 * CPB);
        @(negedge clk);
        check("b2b_overrun_pulses", ovr_cnt - base_o, 32'd1);
        check("b2b_no_ferr", ferr_cnt - base_f, 32'd0);
        for (int i = 0; i < 8; i++) pop_expect("b2b_pop", 8'(i));
        @(negedge clk);
        check("b2b_empty", {31'd0, o_valid}, 32'd0);

        // 100-cycle low glitch on an idle line
        base_o = ovr_cnt;
        base_f = ferr_cnt;
        rx = 1'b0;
        wait_cycles(50);
        @(negedge clk);
        check("glitch_busy", {31'd0, o_busy}, 32'd1);
        wait_cycles(50);
        rx = 1'b1;
        wait_cycles(2 * CPB);
        @(negedge clk);
        check("glitch_idle", {31'd0, o_busy}, 32'd0);
        check("glitch_no_push", {31'd0, o_valid}, 32'd0);
        check("glitch_no_flags", (ferr_cnt - base_f) + (ovr_cnt - base_o), 32'd0);

        // Reset in the middle of a frame, with a byte already queued
        base_f = ferr_cnt;
        send_frame(8'h77, 1'b1, 1'b0);
        rx = 1'b1;
        wait_cycles(CPB);
        @(negedge clk);
        check("pre_rst_queued", {31'd0, o_valid}, 32'd1);
        rx = 1'b0;
        wait_cycles(CPB);
        rx = 1'b1;
        wait_cycles(4 * CPB);
        @(negedge clk);
        check("mid_frame_busy", {31'd0, o_busy}, 32'd1);
        rst = 1'b1;
        #1;
        check("midrst_busy", {31'd0, o_busy}, 32'd0);
        check("midrst_valid", {31'd0, o_valid}, 32'd0);
        check("midrst_data", {24'd0, o_data}, 32'd0);
        wait_cycles(3);
        rst = 1'b0;
        wait_cycles(CPB);
        send_frame(8'h5A, 1'b1, 1'b0);
        rx = 1'b1;
        wait_cycles(2 * CPB);
        pop_expect("after_rst_pop", 8'h5A);
        @(negedge clk);
        check("after_rst_empty", {31'd0, o_valid}, 32'd0);
        check("after_rst_no_ferr", ferr_cnt - base_f, 32'd0);

`ifdef UART_RX_PARITY_EN
        // Bad parity with a good stop bit, then good parity
        base_f = ferr_cnt;
        send_frame(8'h07, 1'b1, 1'b1);
        rx = 1'b1;
        wait_cycles(2 * CPB);
        @(negedge clk);
        check("par_bad_ferr", ferr_cnt - base_f, 32'd1);
        check("par_bad_no_push", {31'd0, o_valid}, 32'd0);
        send_frame(8'h07, 1'b1, 1'b0);
        rx = 1'b1;
        wait_cycles(2 * CPB);
        pop_expect("par_good_pop", 8'h07);
`endif

        // Random frames against a queue model: good frames are stored until the FIFO is full
        base_f = ferr_cnt;
        base_o = ovr_cnt;
        exp_f = 0;
        exp_o = 0;
        for (int i = 0; i < 10; i++) begin
            d = 8'($urandom);
            stop = ($urandom_range(0, 3) != 0);
`ifdef UART_RX_PARITY_EN
            flip = ($urandom_range(0, 4) == 0);
`else
            flip = 1'b0;
`endif
            send_frame(d, stop, flip);
            rx = 1'b1;
            wait_cycles(CPB);
            if (!stop || flip) exp_f++;
            else if (q.size() < DEPTH) q.push_back(d);
            else exp_o++;
        end
        wait_cycles(CPB);
        @(negedge clk);
        check("rand_ferr_count", ferr_cnt - base_f, exp_f);
        check("rand_ovr_count", ovr_cnt - base_o, exp_o);
        while (q.size() > 0) pop_expect("rand_pop", q.pop_front());
        @(negedge clk);
        check("rand_empty", {31'd0, o_valid}, 32'd0);

        check("ferr_ovr_exclusive", both_cnt, 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
